// File: rtl/frame_sched_arbiter.sv
// Round-robin front end for a shared parity frame generator: it captures one requester's
// 16-byte frame, starts the generator, tags and parity-checks the returned words.
module frame_sched_arbiter #(
  parameter int NREQ        = 4,
  parameter int FRAME_WORDS = 16,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 halt,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*128-1:0]  req_frame,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      done,
  output logic                 gen_start,
  output logic [127:0]         gen_frame,
  input  logic [8:0]           gen_data,
  output logic                 out_valid,
  output logic [8:0]           out_data,
  output logic [2:0]           out_src,
  output logic                 busy,
  output logic [7:0]           err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  localparam int             GAP_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [7:0]     LAST_WORD  = 8'(FRAME_WORDS - 1);
  localparam logic [7:0]     LAST_GAP   = 8'(GAP_LAST_I);
  localparam logic [2:0]     LAST_REQ   = 3'(NREQ - 1);
  localparam logic [3:0]     NREQ_4     = 4'(NREQ);

  state_t          state, state_nxt;
  logic [7:0]      cnt, cnt_nxt;
  logic [2:0]      rr_ptr;
  logic [7:0]      req_ext;
  logic [3:0]      cand;
  logic            win_found;
  logic [2:0]      win_idx;
  logic            grant;
  logic [NREQ-1:0] src_onehot;

  function automatic logic parity_err(input logic [8:0] w);
    return w[8] != (^w[7:0]);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Round-robin search: first asserted request at or after rr_ptr, wrapping.
  always_comb begin
    req_ext   = 8'(req);
    cand      = 4'd0;
    win_found = 1'b0;
    win_idx   = 3'd0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr} + 4'(k);
      if (cand >= NREQ_4) cand = cand - NREQ_4;
      if (!win_found && req_ext[cand[2:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[2:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    grant     = 1'b0;
    case (state)
      S_IDLE: begin
        if (!halt && win_found) begin
          grant     = 1'b1;
          state_nxt = S_START;
        end
      end
      S_START: begin
        state_nxt = S_BUSY;
        cnt_nxt   = 8'd0;
      end
      S_BUSY: begin
        if (cnt == LAST_WORD) begin
          cnt_nxt   = 8'd0;
          state_nxt = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      S_GAP: begin
        if (cnt == LAST_GAP) begin
          cnt_nxt   = 8'd0;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Strobes decode straight from the state register so an async reset clears them at once.
  assign src_onehot = NREQ'(1) << out_src;
  assign gen_start  = (state == S_START);
  assign ack        = gen_start ? src_onehot : '0;
  assign out_valid  = (state == S_BUSY);
  assign out_data   = gen_data;
  assign done       = (out_valid && cnt == LAST_WORD) ? src_onehot : '0;
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= 8'd0;
      rr_ptr    <= 3'd0;
      out_src   <= 3'd0;
      gen_frame <= 128'd0;
      err_cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (grant) begin
        rr_ptr    <= (win_idx == LAST_REQ) ? 3'd0 : win_idx + 3'd1;
        out_src   <= win_idx;
        gen_frame <= req_frame[{win_idx, 7'd0} +: 128];
      end
      if (out_valid && parity_err(gen_data)) err_cnt <= sat_inc(err_cnt);
    end
  end

endmodule

// File: tb/tb_frame_sched_arbiter.sv
// Scoreboard bench for frame_sched_arbiter: directed requests push expected grants and
// words; a negedge monitor pops and compares. A second GAP_CYCLES=0 instance checks period.
module tb_frame_sched_arbiter;

  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              halt = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*128-1:0] req_frame = '0;
  logic [NREQ-1:0]   ack, done;
  logic              gen_start, out_valid, busy;
  logic [127:0]      gen_frame;
  logic [8:0]        gen_data = 9'd0;
  logic [8:0]        out_data;
  logic [2:0]        out_src;
  logic [7:0]        err_cnt;

  logic              rst1 = 1'b0;
  logic [1:0]        req1 = '0;
  logic [255:0]      req_frame1 = '0;
  logic [1:0]        ack1, done1;
  logic              gen_start1, out_valid1, busy1;
  logic [127:0]      gen_frame1;
  logic [8:0]        out_data1;
  logic [2:0]        out_src1;
  logic [7:0]        err_cnt1;
  logic              d1_fin = 1'b0;

  frame_sched_arbiter #(.NREQ(NREQ), .FRAME_WORDS(16), .GAP_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .halt(halt), .req(req), .req_frame(req_frame),
    .ack(ack), .done(done), .gen_start(gen_start), .gen_frame(gen_frame),
    .gen_data(gen_data), .out_valid(out_valid), .out_data(out_data),
    .out_src(out_src), .busy(busy), .err_cnt(err_cnt)
  );

  frame_sched_arbiter #(.NREQ(2), .FRAME_WORDS(16), .GAP_CYCLES(0)) dut_gap0 (
    .clk(clk), .reset(rst1), .halt(1'b0), .req(req1), .req_frame(req_frame1),
    .ack(ack1), .done(done1), .gen_start(gen_start1), .gen_frame(gen_frame1),
    .gen_data(9'h000), .out_valid(out_valid1), .out_data(out_data1),
    .out_src(out_src1), .busy(busy1), .err_cnt(err_cnt1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int src; logic [127:0] frame; int cyc; } grant_t;
  typedef struct { logic [8:0] data; int src; logic [NREQ-1:0] dn; int cyc; } word_t;
  grant_t gq[$];
  word_t  wq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int exp_err = 0;
  logic [15:0]  fmask = 16'h0000;
  logic [127:0] frm_a;
  logic [127:0] frm [NREQ];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm, input logic [127:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %0h with nothing expected (cycle %0d)", nm, act, cyc);
  endtask

  function automatic logic [NREQ-1:0] oh(input int s);
    logic [NREQ-1:0] one;
    one = 1;
    return one << s;
  endfunction

  task automatic exp_frame(input int src, input logic [127:0] f, input logic [15:0] fm, input int c);
    grant_t g;
    word_t  w;
    logic [7:0] b;
    g.src = src; g.frame = f; g.cyc = c;
    gq.push_back(g);
    for (int i = 0; i < 16; i++) begin
      b      = f[8*i +: 8];
      w.data = {(^b) ^ fm[i], b};
      w.src  = src;
      w.dn   = (i == 15) ? oh(src) : '0;
      w.cyc  = c + 1 + i;
      wq.push_back(w);
      if (fm[i]) exp_err = (exp_err >= 255) ? 255 : exp_err + 1;
    end
  endtask

  task automatic capture(output int c);
    @(posedge clk);
    #1;
    c = cyc;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_idle(input string nm);
    int t;
    t = 0;
    while (busy !== 1'b0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk(nm, busy, 0);
  endtask

  // Generator model: answers gen_start with the captured frame's bytes plus even parity.
  initial begin
    int  widx;
    bit  first;
    logic [7:0] b;
    widx = 0; first = 0;
    forever begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        if (first) widx = 0;
        else if (widx < 15) widx++;
        first = 0;
      end
      if (gen_start) first = 1;
      b = gen_frame[8*widx +: 8];
      gen_data = {(^b) ^ fmask[widx], b};
    end
  end

  // Monitor: every ack and every output word is checked against the scoreboard queues.
  initial begin
    grant_t g;
    word_t  w;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (gen_start !== (ack != 0)) chk("gen_start_vs_ack", gen_start, ack != 0);
        if (ack != 0) begin
          if (gq.size() == 0) fail_now("unexpected_ack", ack);
          else begin
            g = gq.pop_front();
            chk("ack", ack, oh(g.src));
            chk("ack_cycle", cyc, g.cyc);
            chk("gen_frame", gen_frame, g.frame);
            chk("ack_out_src", out_src, g.src);
          end
        end
        if (out_valid) begin
          if (wq.size() == 0) fail_now("unexpected_word", out_data);
          else begin
            w = wq.pop_front();
            chk("out_data", out_data, w.data);
            chk("out_src", out_src, w.src);
            chk("done", done, w.dn);
            chk("word_cycle", cyc, w.cyc);
          end
        end else if (done != 0) begin
          fail_now("stray_done", done);
        end
      end
    end
  end

  // GAP_CYCLES=0 instance: two requesters alternate with an 18-cycle grant period.
  initial begin
    int c0, t;
    repeat (3) @(negedge clk);
    rst1 = 1'b1;
    @(negedge clk);
    req1 = 2'b11;
    capture(c0);
    for (int k = 0; k < 5; k++) begin
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (ack1 == 0 && t < 40);
      chk("gap0_ack", ack1, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk("gap0_period", cyc, c0 + 18 * k);
    end
    req1 = 2'b00;
    chk("gap0_err_cnt", err_cnt1, 0);
    d1_fin = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, t;
    for (int j = 0; j < 16; j++) frm_a[8*j +: 8] = (j < 6) ? 8'(8'hAA + 8'h11 * j) : 8'(j - 5);
    for (int i = 0; i < NREQ; i++)
      for (int j = 0; j < 16; j++) frm[i][8*j +: 8] = 8'(i * 37 + j * 13 + 5);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    chk("rst_done", done, 0);
    chk("rst_gen_start", gen_start, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_gen_frame", gen_frame, 0);
    chk("rst_out_src", out_src, 0);
    chk("rst_err_cnt", err_cnt, 0);
    reset = 1'b1;
    @(negedge clk);

    // Single request from requester 2
    req = 4'b0100;
    req_frame = {NREQ{128'hDEAD_BEEF_0123_4567_89AB_CDEF_5A5A_A5A5}};
    req_frame[2*128 +: 128] = frm_a;
    capture(c);
    exp_frame(2, frm_a, 16'h0000, c);
    @(negedge clk);
    req = 4'b0000;
    req_frame = '0;
    wait_idle("t1_idle");
    chk("t1_err_cnt", err_cnt, 0);

    // Clean restart, then all four requesting continuously
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) req_frame[i*128 +: 128] = frm[i];
    req = 4'b1111;
    capture(c);
    for (int k = 0; k < 8; k++) exp_frame(k % NREQ, frm[k % NREQ], 16'h0000, c + 20 * k);
    wait_cyc(c + 140);
    req = 4'b0000;
    wait_idle("t2_idle");

    // Parity faults on words 3 and 9, then saturation
    fmask = 16'h0208;
    req = 4'b0001;
    capture(c);
    exp_frame(0, frm[0], fmask, c);
    @(negedge clk);
    req = 4'b0000;
    wait_idle("t3_idle");
    chk("t3_err_cnt_2", err_cnt, exp_err);
    fmask = 16'hFFFF;
    req = 4'b0001;
    capture(c);
    for (int k = 0; k < 19; k++) exp_frame(0, frm[0], fmask, c + 20 * k);
    wait_cyc(c + 360);
    req = 4'b0000;
    wait_idle("t3_sat_idle");
    chk("t3_err_cnt_sat", err_cnt, exp_err);
    fmask = 16'h0000;

    // Halt during BUSY with requesters 0 and 1 pending
    req = 4'b0100;
    capture(c);
    exp_frame(2, frm[2], 16'h0000, c);
    @(negedge clk);
    req = 4'b0000;
    wait_cyc(c + 6);
    halt = 1'b1;
    req  = 4'b0011;
    wait_cyc(c + 40);
    chk("t4_halted_idle", busy, 0);
    halt = 1'b0;
    capture(c);
    exp_frame(0, frm[0], 16'h0000, c);
    exp_frame(1, frm[1], 16'h0000, c + 20);
    wait_cyc(c + 20);
    req = 4'b0000;
    wait_idle("t4_idle");

    // Asynchronous reset at BUSY word 7
    req = 4'b0010;
    capture(c);
    exp_frame(1, frm[1], 16'h0000, c);
    @(negedge clk);
    req = 4'b0000;
    wait_cyc(c + 8);
    #1;
    reset = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_out_valid", out_valid, 0);
    chk("t5_done", done, 0);
    chk("t5_ack", ack, 0);
    chk("t5_gen_start", gen_start, 0);
    chk("t5_gen_frame", gen_frame, 0);
    chk("t5_out_src", out_src, 0);
    chk("t5_err_cnt", err_cnt, 0);
    wq.delete();
    gq.delete();
    exp_err = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    req = 4'b1000;
    capture(c);
    exp_frame(3, frm[3], 16'h0000, c);
    @(negedge clk);
    req = 4'b0000;
    wait_idle("t5_idle");
    chk("t5_err_after", err_cnt, 0);

    t = 0;
    while (!d1_fin && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("gap0_finished", d1_fin, 1);
    repeat (2) @(negedge clk);
    chk("grant_queue_drained", gq.size(), 0);
    chk("word_queue_drained", wq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
